// File: rtl/tqvp_input_conditioner_pkg.sv
// Shared constants and types for the eight-channel input conditioner.
package tqvp_input_conditioner_pkg;

   localparam int unsigned NUM_CH = 8;
   localparam int unsigned CNT_W  = 8;
   localparam int unsigned ADDR_W = 4;
   localparam int unsigned DATA_W = 8;

   localparam logic [ADDR_W-1:0] ADDR_DEBOUNCE    = 4'h0;
   localparam logic [ADDR_W-1:0] ADDR_ENABLE      = 4'h1;
   localparam logic [ADDR_W-1:0] ADDR_POLARITY    = 4'h2;
   localparam logic [ADDR_W-1:0] ADDR_LEVEL       = 4'h3;
   localparam logic [ADDR_W-1:0] ADDR_STICKY_RISE = 4'h4;
   localparam logic [ADDR_W-1:0] ADDR_STICKY_FALL = 4'h5;

   localparam logic [DATA_W-1:0] DEBOUNCE_RST = 8'h04;
   localparam logic [DATA_W-1:0] ENABLE_RST   = 8'hFF;
   localparam logic [DATA_W-1:0] POLARITY_RST = 8'h00;

   typedef struct packed {
      logic [CNT_W-1:0]  debounce;
      logic [NUM_CH-1:0] enable;
      logic [NUM_CH-1:0] polarity;
   } cfg_t;

   // Write-1-to-clear update where a simultaneous set takes priority.
   function automatic logic [NUM_CH-1:0] w1c_update(input logic [NUM_CH-1:0] cur,
                                                    input logic [NUM_CH-1:0] clr,
                                                    input logic [NUM_CH-1:0] set);
      return (cur & ~clr) | set;
   endfunction

endpackage

// File: rtl/tqvp_debounce_channel.sv
// One input channel: two-flop synchroniser, polarity, threshold debounce and edge pulses.
module tqvp_debounce_channel
   import tqvp_input_conditioner_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             pin,
   input  logic             polarity,
   input  logic             enable,
   input  logic [CNT_W-1:0] thresh,
   output logic             level,
   output logic             rise,
   output logic             fall
);

   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic             level_q, level_d;
   logic             rise_q, rise_d;
   logic             fall_q, fall_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             p;

   // Counter only advances while p disagrees with the level; >= lets a lowered threshold commit at once.
   always_comb begin
      sync1_d = pin;
      sync2_d = sync1_q;
      level_d = level_q;
      cnt_d   = cnt_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      p       = sync2_q ^ polarity;
      if (!enable) begin
         cnt_d = '0;
      end else if (p == level_q) begin
         cnt_d = '0;
      end else if (cnt_q >= thresh) begin
         level_d = p;
         cnt_d   = '0;
         rise_d  = p;
         fall_d  = ~p;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         level_q <= level_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         cnt_q   <= cnt_d;
      end
   end

   assign level = level_q;
   assign rise  = rise_q;
   assign fall  = fall_q;

endmodule

// File: rtl/tqvp_input_conditioner.sv
// Eight-channel input conditioner: register file, sticky edge flags, read mux and channel array.
module tqvp_input_conditioner
   import tqvp_input_conditioner_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NUM_CH-1:0]   ui_in,
   input  logic [ADDR_W-1:0]   address,
   input  logic                data_write,
   input  logic [DATA_W-1:0]   data_in,
   output logic [DATA_W-1:0]   data_out,
   output logic [NUM_CH-1:0]   level_out,
   output logic [NUM_CH-1:0]   rise_pulse,
   output logic [NUM_CH-1:0]   fall_pulse
);

   cfg_t              cfg_q, cfg_d;
   logic [NUM_CH-1:0] sticky_rise_q, sticky_rise_d;
   logic [NUM_CH-1:0] sticky_fall_q, sticky_fall_d;
   logic [NUM_CH-1:0] clr_rise, clr_fall;

   // Register writes and sticky flag maintenance.
   always_comb begin
      cfg_d    = cfg_q;
      clr_rise = '0;
      clr_fall = '0;
      if (data_write) begin
         case (address)
            ADDR_DEBOUNCE:    cfg_d.debounce = data_in;
            ADDR_ENABLE:      cfg_d.enable   = data_in;
            ADDR_POLARITY:    cfg_d.polarity = data_in;
            ADDR_STICKY_RISE: clr_rise       = data_in;
            ADDR_STICKY_FALL: clr_fall       = data_in;
            default:          ;
         endcase
      end
      sticky_rise_d = w1c_update(sticky_rise_q, clr_rise, rise_pulse);
      sticky_fall_d = w1c_update(sticky_fall_q, clr_fall, fall_pulse);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cfg_q         <= '{debounce: DEBOUNCE_RST, enable: ENABLE_RST, polarity: POLARITY_RST};
         sticky_rise_q <= '0;
         sticky_fall_q <= '0;
      end else begin
         cfg_q         <= cfg_d;
         sticky_rise_q <= sticky_rise_d;
         sticky_fall_q <= sticky_fall_d;
      end
   end

   // Zero-latency read path.
   always_comb begin
      data_out = '0;
      case (address)
         ADDR_DEBOUNCE:    data_out = cfg_q.debounce;
         ADDR_ENABLE:      data_out = cfg_q.enable;
         ADDR_POLARITY:    data_out = cfg_q.polarity;
         ADDR_LEVEL:       data_out = level_out;
         ADDR_STICKY_RISE: data_out = sticky_rise_q;
         ADDR_STICKY_FALL: data_out = sticky_fall_q;
         default:          data_out = '0;
      endcase
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      tqvp_debounce_channel u_ch (
         .clk      (clk),
         .rst_n    (rst_n),
         .pin      (ui_in[i]),
         .polarity (cfg_q.polarity[i]),
         .enable   (cfg_q.enable[i]),
         .thresh   (cfg_q.debounce),
         .level    (level_out[i]),
         .rise     (rise_pulse[i]),
         .fall     (fall_pulse[i])
      );
   end

endmodule

// File: tb/tb_tqvp_input_conditioner.sv
// Randomised bench for tqvp_input_conditioner against a cycle-level behavioural model.
module tb_tqvp_input_conditioner;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] ui_in;
   logic [3:0] address;
   logic       data_write;
   logic [7:0] data_in;
   logic [7:0] data_out;
   logic [7:0] level_out;
   logic [7:0] rise_pulse;
   logic [7:0] fall_pulse;

   int checks = 0;
   int errors = 0;

   tqvp_input_conditioner dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ui_in      (ui_in),
      .address    (address),
      .data_write (data_write),
      .data_in    (data_in),
      .data_out   (data_out),
      .level_out  (level_out),
      .rise_pulse (rise_pulse),
      .fall_pulse (fall_pulse)
   );

   always #5 clk = ~clk;

   // Model state: the pin samples from the last two edges, registers, and per-channel run lengths.
   logic [7:0] m_seen1, m_seen2;
   logic [7:0] m_T, m_en, m_pol;
   logic [7:0] m_level, m_rise, m_fall, m_srise, m_sfall;
   int         m_run [8];

   task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %02h expected %02h", name, $time, act, exp);
      end
   endtask

   function automatic logic [7:0] m_read(input logic [3:0] a);
      case (a)
         4'h0:    return m_T;
         4'h1:    return m_en;
         4'h2:    return m_pol;
         4'h3:    return m_level;
         4'h4:    return m_srise;
         4'h5:    return m_sfall;
         default: return 8'h00;
      endcase
   endfunction

   task automatic model_step();
      logic [7:0] nl, nr, nf, clr_r, clr_f;
      logic       want;
      if (!rst_n) begin
         m_seen1 = '0; m_seen2 = '0;
         m_T = 8'h04; m_en = 8'hFF; m_pol = 8'h00;
         m_level = '0; m_rise = '0; m_fall = '0; m_srise = '0; m_sfall = '0;
         for (int i = 0; i < 8; i++) m_run[i] = 0;
         return;
      end
      nl = m_level; nr = '0; nf = '0;
      for (int i = 0; i < 8; i++) begin
         // The channel sees the pin as it was two edges ago, through the polarity setting.
         want = m_seen2[i] ^ m_pol[i];
         if (!m_en[i] || want == m_level[i]) begin
            m_run[i] = 0;
         end else if (m_run[i] >= int'(m_T)) begin
            nl[i] = want;
            m_run[i] = 0;
            if (want) nr[i] = 1'b1; else nf[i] = 1'b1;
         end else begin
            m_run[i] = m_run[i] + 1;
         end
      end
      clr_r = (data_write && address == 4'h4) ? data_in : 8'h00;
      clr_f = (data_write && address == 4'h5) ? data_in : 8'h00;
      m_srise = (m_srise & ~clr_r) | m_rise;
      m_sfall = (m_sfall & ~clr_f) | m_fall;
      if (data_write) begin
         if (address == 4'h0) m_T   = data_in;
         if (address == 4'h1) m_en  = data_in;
         if (address == 4'h2) m_pol = data_in;
      end
      m_seen2 = m_seen1;
      m_seen1 = ui_in;
      m_level = nl; m_rise = nr; m_fall = nf;
   endtask

   // Compare process: advance the model on every edge and check all outputs just after it.
   initial begin
      forever begin
         @(posedge clk);
         model_step();
         #1;
         chk8("level_out", level_out, m_level);
         chk8("rise_pulse", rise_pulse, m_rise);
         chk8("fall_pulse", fall_pulse, m_fall);
         chk8("data_out", data_out, m_read(address));
      end
   end

   task automatic wr(input logic [3:0] a, input logic [7:0] d);
      @(negedge clk);
      address = a; data_in = d; data_write = 1'b1;
      @(negedge clk);
      data_write = 1'b0;
   endtask

   logic [3:0] rst_addr [7];
   logic [7:0] rst_exp  [7];

   initial begin
      rst_n = 1'b0; ui_in = '0; address = '0; data_write = 1'b0; data_in = '0;
      rst_addr = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'hF};
      rst_exp  = '{8'h04, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      repeat (3) @(negedge clk);
      for (int k = 0; k < 7; k++) begin
         address = rst_addr[k];
         #1 chk8("reset_read", data_out, rst_exp[k]);
      end
      chk8("reset_level", level_out, 8'h00);
      chk8("reset_pulses", rise_pulse | fall_pulse, 8'h00);

      // T=4: pin change before edge 1 must commit at edge 7.
      @(negedge clk);
      rst_n = 1'b1; address = 4'h4; ui_in = 8'h01;
      repeat (6) @(posedge clk);
      #2 chk8("edge6_level", level_out & 8'h01, 8'h00);
      @(posedge clk);
      #2 chk8("edge7_level", level_out, 8'h01);
      chk8("edge7_rise", rise_pulse, 8'h01);
      @(posedge clk);
      #2 chk8("edge8_rise", rise_pulse, 8'h00);
      chk8("sticky_rise_set", data_out, 8'h01);
      wr(4'h4, 8'h01);
      #1 chk8("sticky_rise_clr", data_out, 8'h00);

      // Four-edge glitch is filtered at T=4 but passes at T=3.
      @(negedge clk) ui_in[1] = 1'b1;
      repeat (4) @(negedge clk);
      ui_in[1] = 1'b0;
      repeat (10) @(negedge clk);
      chk8("glitch_t4_level", level_out & 8'h02, 8'h00);
      chk8("glitch_t4_sticky", data_out, 8'h00);
      wr(4'h0, 8'h03);
      @(negedge clk) ui_in[1] = 1'b1;
      repeat (4) @(negedge clk);
      ui_in[1] = 1'b0;
      repeat (10) @(negedge clk);
      address = 4'h4;
      #1 chk8("glitch_t3_sticky", data_out, 8'h02);

      // Polarity flip on a steady low pin with T=0 produces a genuine rise.
      wr(4'h0, 8'h00);
      wr(4'h2, 8'h04);
      repeat (4) @(negedge clk);
      chk8("pol_level", level_out & 8'h04, 8'h04);
      wr(4'h2, 8'h00);
      repeat (4) @(negedge clk);

      // Disabled channel 0 stays frozen while the pin toggles, then tracks after re-enable.
      wr(4'h0, 8'h04);
      wr(4'h1, 8'hFE);
      for (int k = 0; k < 4; k++) begin
         ui_in[0] = ~ui_in[0];
         repeat (12) @(negedge clk);
      end
      ui_in[0] = 1'b0;
      repeat (12) @(negedge clk);
      chk8("disabled_frozen", level_out & 8'h01, 8'h01);
      wr(4'h1, 8'hFF);
      repeat (8) @(negedge clk);
      chk8("reenable_track", level_out & 8'h01, 8'h00);

      // A W1C write landing in the same cycle as fall_pulse[3] must leave the flag set.
      wr(4'h0, 8'h00);
      @(negedge clk) ui_in[3] = 1'b1;
      repeat (6) @(negedge clk);
      ui_in[3] = 1'b0;
      repeat (3) @(negedge clk);
      chk8("fall3_now", fall_pulse, 8'h08);
      address = 4'h5; data_in = 8'h08; data_write = 1'b1;
      @(negedge clk);
      data_write = 1'b0;
      #1 chk8("sticky_set_wins", data_out & 8'h08, 8'h08);
      wr(4'h5, 8'h08);
      #1 chk8("sticky_fall_clr", data_out & 8'h08, 8'h00);

      // Asynchronous reset in the middle of a long count on channel 5.
      wr(4'h0, 8'h14);
      @(negedge clk) ui_in[5] = 1'b1;
      repeat (8) @(negedge clk);
      #2 rst_n = 1'b0; ui_in = '0; address = 4'h0;
      #1 chk8("midrst_level", level_out, 8'h00);
      chk8("midrst_pulses", rise_pulse | fall_pulse, 8'h00);
      chk8("midrst_debounce", data_out, 8'h04);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);

      // Random traffic: pin toggles at two rates, random register writes, one extra reset.
      for (int n = 0; n < 4000; n++) begin
         @(negedge clk);
         data_write = 1'b0;
         for (int i = 0; i < 8; i++)
            if ($urandom_range(0, ((n / 500) % 2 == 1) ? 30 : 6) == 0) ui_in[i] = ~ui_in[i];
         address = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 15) == 0) begin
            data_write = 1'b1;
            if (address == 4'h0)      data_in = 8'($urandom_range(0, 6));
            else if (address == 4'h1) data_in = 8'($urandom) | 8'($urandom);
            else                      data_in = 8'($urandom);
         end
         if (n == 2500) rst_n = 1'b0;
         if (n == 2503) rst_n = 1'b1;
      end
      @(negedge clk);
      data_write = 1'b0;
      repeat (4) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
